// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic pipeline register placed between two MIPS core
// stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
//
// Adds a valid/ready handshake and an optional second (skid) entry. The skid
// entry lets In_Ready come straight from a flop. The stage also tracks the
// restart PC for branch delay slots, and flags bubbles created by a flush.
//
// Parameters:
//   CTRL_W  control field width (zeroed on flush or bubble)
//   DATA_W  data field width (kept across flush for exception use)
//   PC_W    PC / restart-PC width
//   SKID    1 = two entries, registered In_Ready
//           0 = one entry, In_Ready = Out_Ready | ~Out_Valid (combinational)
//
// Ports:
//   CLK, RST            clock, asynchronous active-high reset
//   In_Valid/In_Ready   upstream handshake
//   In_Ctrl/Data/PC     incoming beat fields
//   In_IsBDS            incoming beat is a branch delay slot
//   Flush               kill held entries and any beat pushed this cycle
//   Out_Valid/Out_Ready downstream handshake
//   Out_Ctrl/Data       head entry fields (Out_Ctrl is 0 when Out_Valid=0)
//   Out_RestartPC       head restart PC (a delay slot reports its branch PC)
//   Out_IsBDS           head is a delay slot
//   Out_IsFlushed       the current bubble was produced by a flush
//   Occupancy           number of valid entries, 0..2
//
// Optional feature, enabled by defining PIPE_STAGE_PERF_EN:
//   Perf_StallCnt [31:0]  cycles with Out_Valid & ~Out_Ready (saturating)
//   Perf_FlushCnt [15:0]  flush cycles that killed >=1 entry (saturating)

module pipe_stage_reg #(
    parameter int unsigned CTRL_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned PC_W   = 32,
    parameter int unsigned SKID   = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              In_Valid,
    output logic              In_Ready,
    input  logic [CTRL_W-1:0] In_Ctrl,
    input  logic [DATA_W-1:0] In_Data,
    input  logic [PC_W-1:0]   In_PC,
    input  logic              In_IsBDS,
    input  logic              Flush,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic [CTRL_W-1:0] Out_Ctrl,
    output logic [DATA_W-1:0] Out_Data,
    output logic [PC_W-1:0]   Out_RestartPC,
    output logic              Out_IsBDS,
    output logic              Out_IsFlushed,
`ifdef PIPE_STAGE_PERF_EN
    output logic [31:0]       Perf_StallCnt,
    output logic [15:0]       Perf_FlushCnt,
`endif
    output logic [1:0]        Occupancy
);

    localparam int unsigned STALL_CNT_W = 32;
    localparam int unsigned FLUSH_CNT_W = 16;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
        logic [PC_W-1:0]   rpc;
        logic              bds;
    } entry_t;

    entry_t          head_q, head_d;
    entry_t          skid_q, skid_d;
    entry_t          in_entry;
    logic            head_valid_q, head_valid_d;
    logic            skid_valid_q, skid_valid_d;
    logic            flushed_q, flushed_d;
    logic            in_ready_q, in_ready_d;
    logic [1:0]      occ_q, occ_d;
    logic [PC_W-1:0] last_pc_q, last_pc_d;
    logic            in_ready;
    logic            push;
    logic            pop;

    // With a skid entry In_Ready comes from a flop; otherwise it must look at Out_Ready.
    assign in_ready = (SKID != 0) ? in_ready_q : (Out_Ready | ~head_valid_q);
    assign push     = In_Valid & in_ready;
    assign pop      = head_valid_q & Out_Ready;

    // Next-state for both entries, restart-PC tracking and the flushed flag.
    always_comb begin
        head_d       = head_q;
        head_valid_d = head_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        flushed_d    = flushed_q;
        last_pc_d    = last_pc_q;

        // A delay slot restarts at its branch, which is the last non-BDS push.
        in_entry.ctrl = In_Ctrl;
        in_entry.data = In_Data;
        in_entry.rpc  = In_IsBDS ? last_pc_q : In_PC;
        in_entry.bds  = In_IsBDS;

        if (Flush) begin
            // Data/restart PC/BDS are kept for exception handling; only ctrl becomes a NOP.
            head_valid_d = 1'b0;
            skid_valid_d = 1'b0;
            head_d.ctrl  = '0;
            flushed_d    = 1'b1;
        end else begin
            if (push && !In_IsBDS) begin
                last_pc_d = In_PC;
            end

            if (head_valid_q && !pop) begin
                // Stall: head holds; a beat accepted now parks in the skid entry.
                if (push && (SKID != 0)) begin
                    skid_d       = in_entry;
                    skid_valid_d = 1'b1;
                end
            end else if (skid_valid_q) begin
                // In_Ready is low while the skid entry is full, so no push competes here.
                head_d       = skid_q;
                head_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else if (push) begin
                head_d       = in_entry;
                head_valid_d = 1'b1;
                flushed_d    = 1'b0;
            end else begin
                head_valid_d = 1'b0;
                head_d.ctrl  = '0;
            end
        end

        in_ready_d = ~skid_valid_d;
        occ_d      = {1'b0, head_valid_d} + {1'b0, skid_valid_d};
    end

    // State registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            head_q       <= '0;
            skid_q       <= '0;
            head_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            flushed_q    <= 1'b0;
            in_ready_q   <= 1'b1;
            occ_q        <= 2'd0;
            last_pc_q    <= '0;
        end else begin
            head_q       <= head_d;
            skid_q       <= skid_d;
            head_valid_q <= head_valid_d;
            skid_valid_q <= skid_valid_d;
            flushed_q    <= flushed_d;
            in_ready_q   <= in_ready_d;
            occ_q        <= occ_d;
            last_pc_q    <= last_pc_d;
        end
    end

    assign In_Ready      = in_ready;
    assign Out_Valid     = head_valid_q;
    assign Out_Ctrl      = head_q.ctrl;
    assign Out_Data      = head_q.data;
    assign Out_RestartPC = head_q.rpc;
    assign Out_IsBDS     = head_q.bds;
    assign Out_IsFlushed = flushed_q;
    assign Occupancy     = occ_q;

`ifdef PIPE_STAGE_PERF_EN
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [FLUSH_CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Saturating stall and effective-flush counters.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (head_valid_q && !Out_Ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end
        if (Flush && (head_valid_q || skid_valid_q) && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + FLUSH_CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign Perf_StallCnt = stall_cnt_q;
    assign Perf_FlushCnt = flush_cnt_q;
`endif

endmodule
